// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver fed by the BCD adder.
// Holds each captured result for at least one full units+tens scan frame.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] tens_in,
  input  logic [3:0] units_in,
  input  logic       flag_in,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshake: a result transfers on a rising edge with in_valid && in_ready.
  // in_ready depends only on state, so upstream must hold its data while
  // in_ready is low.

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;  // 0 = units, 1 = tens
  logic [3:0]    tens_q, units_q;
  logic          err_q;
  logic          capture;
  logic          wrap;

  assign in_ready  = (state_q != SHOW);
  assign capture   = in_valid && in_ready;
  assign wrap      = (cnt_q == CNT_MAX);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      err_q   <= 1'b0;
    end else if (capture) begin
      tens_q  <= tens_in;
      units_q <= units_in;
      err_q   <= flag_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (state_q != IDLE) begin
      if (wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        // Frame completes at the end of the tens phase.
        if (state_q == SHOW && phase_q) state_d = HOLD;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (capture) begin
      state_d = SHOW;
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;
    endcase
  endfunction

  always_comb begin
    seg     = 7'h00;
    dig_sel = 2'b00;
    err     = err_q;
    if (state_q != IDLE) begin
      dig_sel = phase_q ? 2'b10 : 2'b01;
      if (err_q) begin
        seg = phase_q ? 7'h79 : 7'h50;
      end else if (phase_q) begin
        // Leading-zero blanking: the tens digit stays selected but dark.
        seg = (tens_q == 4'd0) ? 7'h00 : bcd_to_seg(tens_q);
      end else begin
        seg = bcd_to_seg(units_q);
      end
    end
  end

endmodule
